// File: rtl/serialdump.sv
// serialdump: bus master that streams a memory range out over UART as
// lowercase ASCII hex words, terminated by a single space.
module serialdump #(
  parameter int LEN_W = 16,
  parameter int GUARD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  s_a,
  input  logic [31:0] s_d,
  input  logic        s_we,
  output logic        s_ready,
  output logic        m_req,
  input  logic        m_gnt,
  output logic [31:0] m_a,
  output logic [31:0] m_d,
  output logic        m_we,
  output logic        m_rd,
  input  logic [31:0] m_spo,
  input  logic        m_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_start,
  input  logic        uart_tx_busy,
  output logic        done
);

  localparam int GW = $clog2(GUARD + 2);

  typedef enum logic [2:0] {
    IDLE, REQ, RD, RWAIT, TX, SPACE, FIN
  } state_e;

  state_e             state_q, state_d;
  logic               m_req_q, m_req_d;
  logic               m_rd_q, m_rd_d;
  logic [31:0]        m_a_q, m_a_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [31:0]        word_q, word_d;
  logic [2:0]         nib_q, nib_d;
  logic [GW-1:0]      guard_q, guard_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               done_q, done_d;

  logic               tx_ok;
  logic [3:0]         nibble;
  logic [31:0]        sw;
  logic [LEN_W-1:0]   cnt_dec;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_a_d      = m_a_q;
    count_d    = count_q;
    word_d     = word_q;
    nib_d      = nib_q;
    tx_data_d  = tx_data_q;
    m_rd_d     = 1'b0;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    guard_d    = (guard_q != '0) ? guard_q - GW'(1) : '0;
    sw         = {s_d[7:0], s_d[15:8], s_d[23:16], s_d[31:24]};
    cnt_dec    = count_q - LEN_W'(1);
    nibble     = word_q[{nib_q, 2'b00} +: 4];
    // guard gap also covers the strobe cycle itself when GUARD is 0
    tx_ok      = !uart_tx_busy && (guard_q == '0) && !tx_start_q;

    if (state_q == IDLE) begin
      if (s_we) begin
        unique case (s_a)
          3'b001: m_a_d = sw;
          3'b011: count_d = sw[LEN_W-1:0];
          3'b010: begin
            m_req_d = 1'b1;
            state_d = REQ;
          end
          default: ;
        endcase
      end
    end else if (m_gnt) begin
      unique case (state_q)
        REQ: state_d = (count_q == '0) ? SPACE : RD;
        RD: begin
          if (m_ready) begin
            m_rd_d  = 1'b1;
            state_d = RWAIT;
          end
        end
        RWAIT: begin
          if (!m_rd_q && m_ready) begin
            word_d  = m_spo;
            nib_d   = 3'd7;
            state_d = TX;
          end
        end
        TX: begin
          if (tx_ok) begin
            tx_data_d  = hexc(nibble);
            tx_start_d = 1'b1;
            guard_d    = GW'(GUARD);
            if (nib_q != 3'd0) begin
              nib_d = nib_q - 3'd1;
            end else begin
              m_a_d   = m_a_q + 32'd4;
              count_d = cnt_dec;
              state_d = (cnt_dec == '0) ? SPACE : RD;
            end
          end
        end
        SPACE: begin
          if (tx_ok) begin
            tx_data_d  = 8'h20;
            tx_start_d = 1'b1;
            guard_d    = GW'(GUARD);
            state_d    = FIN;
          end
        end
        FIN: begin
          if (tx_ok) begin
            m_req_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_rd_q     <= 1'b0;
      m_a_q      <= '0;
      count_q    <= '0;
      word_q     <= '0;
      nib_q      <= '0;
      guard_q    <= '0;
      tx_data_q  <= 8'h20;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_rd_q     <= m_rd_d;
      m_a_q      <= m_a_d;
      count_q    <= count_d;
      word_q     <= word_d;
      nib_q      <= nib_d;
      guard_q    <= guard_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
    end
  end

  assign s_ready       = !s_we;
  assign m_req         = m_req_q;
  assign m_a           = m_a_q;
  assign m_d           = '0;
  assign m_we          = 1'b0;
  assign m_rd          = m_rd_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_start = tx_start_q;
  assign done          = done_q;

endmodule

// File: tb/tb_serialdump.sv
// tb_serialdump: directed dumps with a character/address scoreboard
// against a memory and UART model.
`timescale 1ns/1ps
module tb_serialdump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  s_a = '0;
  logic [31:0] s_d = '0;
  logic        s_we = 1'b0;
  logic        s_ready;
  logic        m_req;
  logic        m_gnt;
  logic [31:0] m_a;
  logic [31:0] m_d;
  logic        m_we;
  logic        m_rd;
  logic [31:0] m_spo;
  logic        m_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy;
  logic        done;

  always #5 clk = ~clk;

  serialdump #(.LEN_W(16), .GUARD(1)) dut (
    .clk(clk), .rst(rst),
    .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_ready(s_ready),
    .m_req(m_req), .m_gnt(m_gnt), .m_a(m_a), .m_d(m_d),
    .m_we(m_we), .m_rd(m_rd), .m_spo(m_spo), .m_ready(m_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
    .uart_tx_busy(uart_tx_busy), .done(done)
  );

  logic [31:0] mem [0:255];
  logic        gnt = 1'b1;
  logic        slow = 1'b0;
  int          busy_len = 3;
  int          busy_cnt = 0;
  int          rd_wait = 0;

  assign m_gnt        = gnt;
  assign m_spo        = mem[m_a[9:2]];
  assign m_ready      = (rd_wait == 0);
  assign uart_tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (uart_tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (m_rd && slow) rd_wait <= 5;
    else if (rd_wait > 0) rd_wait <= rd_wait - 1;
  end

  logic [7:0]  exp_ch[$];
  logic [31:0] exp_a[$];
  logic [7:0]  got_ch[$];
  logic [31:0] wv [0:2];
  int n_cmp = 0;
  int n_err = 0;
  int tx_seen = 0;
  int done_seen = 0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (uart_tx_start) begin
        tx_seen <= tx_seen + 1;
        got_ch.push_back(uart_tx_data);
        if (exp_ch.size() == 0) flag("unexpected_char");
        else check("char", {24'h0, uart_tx_data}, {24'h0, exp_ch.pop_front()});
        check("strobe_not_busy", {31'h0, uart_tx_busy}, 32'h0);
        check("strobe_spacing", {31'h0, prev_start}, 32'h0);
        check("tx_grant_held", {31'h0, m_gnt}, 32'h1);
      end
      if (m_rd) begin
        if (exp_a.size() == 0) flag("unexpected_rd");
        else check("rd_addr", m_a, exp_a.pop_front());
        check("rd_grant_held", {31'h0, m_gnt}, 32'h1);
      end
      if (done) done_seen <= done_seen + 1;
    end
    prev_start <= uart_tx_start;
  end

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h61 + {4'h0, n} - 8'd10;
  endfunction

  task automatic prep(input logic [31:0] addr, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(4 * i);
      mem[a[9:2]] = wv[i];
      exp_a.push_back(a);
      for (int k = 7; k >= 0; k--) exp_ch.push_back(hexc(wv[i][4*k +: 4]));
    end
    exp_ch.push_back(8'h20);
  endtask

  task automatic ctrl_write(input logic [2:0] a, input logic [31:0] d);
    s_a = a;
    s_d = d;
    s_we = 1'b1;
    #1 check("s_ready_low", {31'h0, s_ready}, 32'h0);
    @(negedge clk);
    s_we = 1'b0;
  endtask

  task automatic wait_done(input logic [31:0] final_a, input int budget,
                           input int base_done);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      flag("done_timeout");
    end else begin
      check("m_req_at_done", {31'h0, m_req}, 32'h0);
      @(negedge clk);
      check("done_one_cycle", {31'h0, done}, 32'h0);
      check("done_count", 32'(done_seen - base_done), 32'd1);
      check("final_m_a", m_a, final_a);
      check("chars_left", 32'(exp_ch.size()), 32'd0);
      check("reads_left", 32'(exp_a.size()), 32'd0);
    end
  endtask

  initial begin
    string s;
    int base;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_m_req", {31'h0, m_req}, 32'h0);
    check("rst_m_rd", {31'h0, m_rd}, 32'h0);
    check("rst_tx_start", {31'h0, uart_tx_start}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_tx_data", {24'h0, uart_tx_data}, 32'h20);
    check("rst_m_a", m_a, 32'h0);
    check("rst_s_ready", {31'h0, s_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // single word, checked against the literal character stream too
    wv[0] = 32'hDEADBEEF;
    prep(32'h100, 1);
    got_ch.delete();
    ctrl_write(3'b001, 32'h00010000);
    ctrl_write(3'b011, 32'h01000000);
    base = done_seen;
    ctrl_write(3'b010, 32'h0);
    wait_done(32'h104, 500, base);
    s = "deadbeef ";
    check("lit_len", 32'(got_ch.size()), 32'd9);
    for (int i = 0; i < 9 && i < got_ch.size(); i++)
      check("lit_char", {24'h0, got_ch[i]}, {24'h0, s[i]});

    // three words
    wv[0] = 32'h01234567;
    wv[1] = 32'h89ABCDEF;
    wv[2] = 32'h00000000;
    prep(32'h200, 3);
    ctrl_write(3'b001, bswap(32'h200));
    ctrl_write(3'b011, bswap(32'd3));
    base = done_seen;
    ctrl_write(3'b010, 32'h0);
    wait_done(32'h20C, 1000, base);

    // empty dump: space only, address untouched
    prep(32'h0, 0);
    ctrl_write(3'b011, 32'h0);
    base = done_seen;
    ctrl_write(3'b010, 32'h0);
    wait_done(32'h20C, 200, base);

    // slow memory and slow UART, continuing from the previous address
    slow = 1'b1;
    busy_len = 100;
    wv[0] = 32'hCAFEF00D;
    wv[1] = 32'h13579BDF;
    wv[2] = 32'h2468ACE0;
    prep(32'h20C, 3);
    ctrl_write(3'b011, bswap(32'd3));
    base = done_seen;
    ctrl_write(3'b010, 32'h0);
    wait_done(32'h218, 5000, base);
    slow = 1'b0;
    busy_len = 3;

    // grant withheld after start
    gnt = 1'b0;
    wv[0] = 32'hA5A5F00F;
    prep(32'h40, 1);
    ctrl_write(3'b001, bswap(32'h40));
    ctrl_write(3'b011, bswap(32'd1));
    base = done_seen;
    ctrl_write(3'b010, 32'h0);
    check("req_while_no_gnt", {31'h0, m_req}, 32'h1);
    repeat (20) begin
      @(negedge clk);
      check("no_rd_wo_gnt", {31'h0, m_rd}, 32'h0);
      check("no_tx_wo_gnt", {31'h0, uart_tx_start}, 32'h0);
    end
    gnt = 1'b1;
    wait_done(32'h44, 500, base);

    // reset after the third character of the first word
    wv[0] = 32'h11223344;
    wv[1] = 32'h55667788;
    prep(32'h80, 2);
    ctrl_write(3'b001, bswap(32'h80));
    ctrl_write(3'b011, bswap(32'd2));
    base = tx_seen;
    ctrl_write(3'b010, 32'h0);
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 500; i++) begin
        if (tx_seen - base >= 3) begin
          hit = 1;
          break;
        end
        @(negedge clk);
      end
      if (!hit) flag("third_char_timeout");
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_m_req", {31'h0, m_req}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_m_a", m_a, 32'h0);
    check("abort_tx_data", {24'h0, uart_tx_data}, 32'h20);
    rst = 1'b0;
    exp_ch.delete();
    exp_a.delete();
    repeat (5) @(negedge clk);
    wv[0] = 32'h9E3779B9;
    prep(32'h60, 1);
    ctrl_write(3'b001, bswap(32'h60));
    ctrl_write(3'b011, bswap(32'd1));
    base = done_seen;
    ctrl_write(3'b010, 32'h0);
    wait_done(32'h64, 500, base);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
